// File: rtl/stream_mux_pkg.sv
// Shared constants and select type for the 4-to-1 round-robin stream mux.
package stream_mux_pkg;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic sel_t sel_inc(sel_t s);
    return s + sel_t'(1);
  endfunction
endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin arbiter: first asserted req at or above ptr, wrapping 3 -> 0.
module rr_arb4
  import stream_mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  sel_t               ptr,
  output logic               gnt_vld,
  output sel_t               gnt_idx
);

  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux4_rr.sv
// 4-to-1 valid/ready stream mux with round-robin arbitration and a registered output tagged by source.
// Optional packet lock on in_last/out_last when STREAM_MUX_LAST_LOCK_EN is defined.
module stream_mux4_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]       in_valid,
  output logic [NUM_SRC-1:0]       in_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [NUM_SRC-1:0]       in_last,
  output logic                     out_last,
`endif
  output logic [WIDTH-1:0]         out_data,
  output sel_t                     out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [NUM_SRC-1:0][WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            req;
  logic                          load, gnt_vld, take;
  sel_t                          gnt_idx;

  logic [WIDTH-1:0] out_data_d, out_data_q;
  sel_t             out_sel_d, out_sel_q, ptr_d, ptr_q;
  logic             out_valid_d, out_valid_q;

  assign src_data = in_data;
  assign load     = !out_valid_q || out_ready;
  assign take     = load && gnt_vld;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic lock_d, lock_q, out_last_d, out_last_q;
  sel_t lock_idx_d, lock_idx_q;

  // While locked only the owning source may compete, even if it is idle.
  always_comb begin
    req = in_valid;
    if (lock_q) begin
      req             = '0;
      req[lock_idx_q] = in_valid[lock_idx_q];
    end
  end
`else
  assign req = in_valid;
`endif

  rr_arb4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Gate with rst_n so nothing handshakes while reset is held.
  always_comb begin
    in_ready = '0;
    if (take && rst_n) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = src_data[gnt_idx];
        out_sel_d  = gnt_idx;
        ptr_d      = sel_inc(gnt_idx);
`ifdef STREAM_MUX_LAST_LOCK_EN
        out_last_d = in_last[gnt_idx];
        lock_d     = !in_last[gnt_idx];
        lock_idx_d = gnt_idx;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux4_rr.sv
// Bench for stream_mux4_rr: directed vector table, reset/lock sequences, and randomized traffic vs a reference model.
module tb_stream_mux4_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid, out_ready;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [3:0]     in_last;
  logic           out_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_mux4_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_LAST_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[16];

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference model state
  int         m_ptr;
  logic       m_vld;
  logic [1:0] m_sel;
  logic [7:0] m_data;
  logic       p_vld [4];
  logic [7:0] p_data[4];
  int         waits [4];

  initial begin
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[6]  = '{4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[9]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[10] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hC2};
    tbl[12] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[13] = '{4'h0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hD3};
    tbl[14] = '{4'h2, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hD3};
    tbl[15] = '{4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};

`ifdef STREAM_MUX_LAST_LOCK_EN
    in_last = 4'hF;
`endif
    in_data = 32'hD3C2B1A0;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sel",   32'(out_sel),   0);
    chk("rst_out_data",  32'(out_data),  0);

    for (int i = 0; i < 16; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_vld));
      chk($sformatf("vec%0d_out_sel", i),   32'(out_sel),   32'(tbl[i].exp_sel));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
    end

    // Reset mid-stream while a beat is held under backpressure
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready",  32'(in_ready),  0);
    chk("midrst_out_data",  32'(out_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("postrst_out_sel",   32'(out_sel),   0);
    chk("postrst_out_valid", 32'(out_valid), 1);
    chk("postrst_out_data",  32'(out_data),  32'hA0);

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Source 1 sends a 3-beat packet; others stay valid and must wait
    do_reset();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("lock_pre_sel", 32'(out_sel), 0);
    for (int b = 0; b < 3; b++) begin
      in_data = {8'hD3, 8'hC2, 8'(8'h11 + b), 8'hA0};
      in_last = (b == 2) ? 4'hF : 4'b1101;
      @(negedge clk);
      chk($sformatf("lock_b%0d_in_ready", b), 32'(in_ready), 32'h2);
      @(posedge clk); #1;
      chk($sformatf("lock_b%0d_sel", b),  32'(out_sel),  1);
      chk($sformatf("lock_b%0d_last", b), 32'(out_last), (b == 2) ? 1 : 0);
      chk($sformatf("lock_b%0d_data", b), 32'(out_data), 32'(8'h11 + b));
    end
    in_last = 4'hF;
    @(posedge clk); #1;
    chk("lock_release_sel", 32'(out_sel), 2);
`endif

    // Randomized traffic against the reference model
    do_reset();
    m_ptr = 0; m_vld = 1'b0; m_sel = 2'd0; m_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      p_vld[i]  = 1'b0;
      p_data[i] = 8'h00;
      waits[i]  = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       load;
      int         g;
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) begin
        if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
          p_vld[i]  = 1'b1;
          p_data[i] = 8'($urandom);
        end
        in_valid[i]        = p_vld[i];
        in_data[i*W +: W]  = p_data[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);

      load = !m_vld || out_ready;
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && p_vld[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'h0;

      @(negedge clk);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      // Fairness measured on the DUT's own grants
      if (in_ready != 4'h0) begin
        for (int i = 0; i < 4; i++) begin
          if (in_ready[i]) waits[i] = 0;
          else if (p_vld[i]) begin
            waits[i]++;
            if (waits[i] > 3) chk($sformatf("rnd_fair_src%0d_waits", i), 32'(waits[i]), 3);
          end
        end
      end

      @(posedge clk); #1;
      if (load) begin
        if (g >= 0) begin
          m_vld    = 1'b1;
          m_sel    = 2'(g);
          m_data   = p_data[g];
          m_ptr    = (g + 1) % 4;
          p_vld[g] = 1'b0;
        end else begin
          m_vld = 1'b0;
        end
      end
      chk("rnd_out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("rnd_out_sel",  32'(out_sel),  32'(m_sel));
        chk("rnd_out_data", 32'(out_data), 32'(m_data));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
